// File: rtl/spi_mem_master_if.sv
// spi_mem_master_if: request/response bundle (start, addr, rw, wdata -> busy, done, rdata) between a requester and spi_mem_master
interface spi_mem_master_if;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  modport master (output start, addr, rw, wdata, input busy, done, rdata);
  modport slave (input start, addr, rw, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_mem_master.sv
// spi_mem_master: turns one req strobe (addr/rw/wdata -> busy/done/rdata) into a 16-bit SPI frame on sclk_pin/cs_pin/mosi_pin, sampling miso_pin
module spi_mem_master #(
  parameter int HALF_PERIOD = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  spi_mem_master_if.slave        req,
  output logic                   sclk_pin,
  output logic                   cs_pin,
  output logic                   mosi_pin,
  input  logic                   miso_pin
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t      state, state_n;
  logic [7:0]  hcnt, hcnt_n;
  logic [3:0]  bcnt, bcnt_n;
  logic        ph, ph_n;
  logic [15:0] frame, frame_n;
  logic [7:0]  rx, rx_n;
  logic [1:0]  miso_s;
  logic        last;
  logic        sclk_n, cs_n, mosi_n, busy_n, done_n;
  logic [7:0]  rdata_n;
  assign last = hcnt == 8'(HALF_PERIOD - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hcnt      <= '0;
      bcnt      <= '0;
      ph        <= 1'b0;
      frame     <= '0;
      rx        <= '0;
      miso_s    <= '0;
      sclk_pin  <= 1'b0;
      cs_pin    <= 1'b1;
      mosi_pin  <= 1'b0;
      req.busy  <= 1'b0;
      req.done  <= 1'b0;
      req.rdata <= '0;
    end else begin
      state     <= state_n;
      hcnt      <= hcnt_n;
      bcnt      <= bcnt_n;
      ph        <= ph_n;
      frame     <= frame_n;
      rx        <= rx_n;
      miso_s    <= {miso_s[0], miso_pin};
      sclk_pin  <= sclk_n;
      cs_pin    <= cs_n;
      mosi_pin  <= mosi_n;
      req.busy  <= busy_n;
      req.done  <= done_n;
      req.rdata <= rdata_n;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req.start ? SETUP : IDLE;
      SETUP:   state_n = last ? SHIFT : SETUP;
      SHIFT:   state_n = (last && ph && bcnt == 4'd15) ? HOLD : SHIFT;
      HOLD:    state_n = last ? GAP : HOLD;
      GAP:     state_n = last ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
    hcnt_n  = (state == IDLE || last) ? '0 : hcnt + 8'd1;
    ph_n    = (state == SHIFT && last) ? ~ph : ph;
    bcnt_n  = state == IDLE ? '0 : (state == SHIFT && last && ph && bcnt != 4'd15) ? bcnt + 4'd1 : bcnt;
    frame_n = (state == IDLE && req.start) ? {req.addr, req.rw, req.rw ? 8'h00 : req.wdata} : frame;
    rx_n    = (state == SHIFT && ph && last) ? {rx[6:0], miso_s[1]} : rx;
  end
  always_comb begin
    cs_n    = !(state_n == SETUP || state_n == SHIFT || state_n == HOLD);
    sclk_n  = state_n == SHIFT && ph_n;
    mosi_n  = state_n == SETUP ? frame_n[15] : state_n == SHIFT ? frame_n[4'd15 - bcnt_n] : 1'b0;
    busy_n  = state_n != IDLE;
    done_n  = state == HOLD && last;
    rdata_n = (done_n && frame[8]) ? rx : req.rdata;
  end
endmodule
